uart_tx_fifo_drain: RTL and testbench
=====================================

# uart_tx_fifo_drain

UART transmit serializer that drains the read side of the asynchronous FIFO in the UART/TX clock domain. Whenever the FIFO reports data, it pops one word with a single-cycle read-increment pulse, latches the word, and shifts it out as a standard UART frame. The frame is start bit, data LSB-first, optional parity, then stop bit. It sits directly downstream of the FIFO and drives the TX pin.

## Interface
- DATA_WIDTH, 8, width of FIFO word and of frame data field
- PRESCALE_WIDTH, 6, width of the PRESCALE port
- CLK  input  1  TX-domain clock, same clock as the FIFO read side
- RST  input  1  synchronous, active-low reset (sampled on rising CLK)
- FIFO_EMPTY  input  1  FIFO empty flag, already synchronous to CLK
- FIFO_RD_DATA  input  DATA_WIDTH  FIFO head word, valid whenever FIFO_EMPTY=0
- FIFO_R_INC  output  1  pop pulse to FIFO read side
- PAR_EN  input  1  1 = insert parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- PRESCALE  input  PRESCALE_WIDTH  CLK cycles per UART bit; 0 is treated as 1
- TX_OUT  output  1  serial line, idle high
- BUSY  output  1  high from the START state through the last STOP cycle

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - FIFO_R_INC = (state==IDLE) & ~FIFO_EMPTY. This is combinational from state and FIFO_EMPTY; never high while FIFO_EMPTY=1 or outside IDLE.
  - On the edge where FIFO_R_INC=1: latch FIFO_RD_DATA into the shift register.
  - On that same edge, latch PAR_EN, PAR_TYP and max(PRESCALE,1). Then go to START.
- **START:** TX_OUT=0 for one bit period, then go to DATA.
- **DATA:**
  - Shift out DATA_WIDTH bits LSB first, one bit period each.
  - A bit counter counts 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if the latched PAR_EN=1, else go to STOP.
- **PARITY:**
  - TX_OUT = ^data when the latched PAR_TYP=0 (even parity).
  - TX_OUT = ~^data when the latched PAR_TYP=1 (odd parity).
  - Parity is computed on the latched word. Duration is one bit period, then go to STOP.
- **STOP:** TX_OUT=1 for one bit period, then go to IDLE.
- **Bit period counter:**
  - Counts 0..P-1, where P is the latched prescale. It clears on every state or bit advance.
  - The counter width is PRESCALE_WIDTH+1, so P up to 2^PRESCALE_WIDTH-1 never overflows.
- **Live input changes:** changes to PAR_EN, PAR_TYP or PRESCALE mid-frame have no effect until the next pop.
- **TX_OUT glitch-freedom:** TX_OUT is registered and must never glitch.

## Timing
- **Reset values:** on a rising CLK with RST=0:
  - state=IDLE, TX_OUT=1, BUSY=0.
  - Counters and shift register = 0.
  - FIFO_R_INC=0 in the following cycle unless FIFO_EMPTY=0.
- **Pop-to-frame latency:**
  - Pop edge at cycle N. TX_OUT falls to 0 at cycle N+1 (registered).
  - BUSY rises at N+1.
- **Frame length:**
  - (1 + DATA_WIDTH + PAR_EN + 1) × P cycles of BUSY=1.
  - Example: DATA_WIDTH=8, P=1, no parity gives 10 cycles.
- **Back-to-back frames:**
  - After the last STOP cycle, exactly one IDLE cycle (TX_OUT=1) precedes the next pop, if FIFO_EMPTY=0.
  - The inter-frame gap is therefore P stop cycles plus 1 idle cycle.
- **Pop rate:** exactly one pop per frame. FIFO_R_INC is never high in two consecutive cycles.
- **Empty FIFO:** if FIFO_EMPTY=1 in IDLE, stay in IDLE with TX_OUT=1 and BUSY=0 indefinitely.
- **FIFO_EMPTY during a frame:** FIFO_EMPTY rising mid-frame has no effect. FIFO_EMPTY falling mid-frame is acted on only on return to IDLE.
- **Reset mid-frame:**
  - The frame is aborted on the reset edge. TX_OUT=1 and BUSY=0 from the next cycle.
  - The already-popped word is discarded and not re-read.

## Configuration
- **UART_TX_PARITY_EN** defined:
  - PARITY state, parity generator and the latched PAR_EN/PAR_TYP are compiled in.
  - Behaviour is as described above.
- **UART_TX_PARITY_EN** undefined:
  - PARITY state and parity logic are removed, and PAR_EN/PAR_TYP are ignored (ports kept, unconnected internally).
  - DATA goes directly to STOP; frame length is (DATA_WIDTH+2)×P.

## Test plan
- **Reset:** reset held 3 cycles with FIFO_EMPTY=0 -> FIFO_R_INC=0 during reset, TX_OUT=1, BUSY=0. After release, first pop occurs in the first cycle.
- **Single byte, no parity, P=1:** FIFO_RD_DATA=0xA5, PAR_EN=0 -> one FIFO_R_INC pulse; TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then idle high.
- **Parity:**
  - 0xA5 with PAR_EN=1, PAR_TYP=0 (even) -> parity bit 0, 11-cycle frame.
  - Same with PAR_TYP=1 (odd) -> parity bit 1.
  - With UART_TX_PARITY_EN undefined -> 10-cycle frame for both.
- **Prescale:**
  - PRESCALE=4, byte 0x01 -> each bit held 4 cycles, BUSY high 40 cycles.
  - PRESCALE=0 -> identical to PRESCALE=1.
  - PRESCALE changed to 2 mid-frame -> current frame unchanged.
- **Streaming:** 3 words 0x11, 0x22, 0x33 with FIFO_EMPTY low throughout -> 3 single-cycle pops, frames in order, exactly 1 idle cycle between frames. BUSY drops for that cycle; no pop after FIFO_EMPTY=1.
- **Reset mid-frame:** reset during DATA bit 3 of 0xFF -> TX_OUT=1 next cycle, no extra pop. After release with FIFO_EMPTY=0, the next word starts a full fresh frame.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops words from the async FIFO read side and serializes each as a UART frame
// Ports: CLK/RST (sync active-low reset), FIFO_EMPTY/FIFO_RD_DATA/FIFO_R_INC (FIFO read side),
//        PAR_EN/PAR_TYP/PRESCALE (frame config, latched on each pop), TX_OUT (idle-high line), BUSY.
// Build option: define UART_TX_PARITY_EN to compile in the parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0]     FIFO_RD_DATA,
  output logic                      FIFO_R_INC,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = PRESCALE_WIDTH + 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic tx_d, bit_end, last_bit;
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit_q;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif
  assign bit_end = cnt_q + CW'(1) == {1'b0, pre_q};
  assign last_bit = bit_q == BW'(DATA_WIDTH - 1);
  // Gated by RST so nothing is popped while reset is held.
  assign FIFO_R_INC = RST && state_q == IDLE && !FIFO_EMPTY;
  assign BUSY = state_q != IDLE;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      pre_q <= '0;
      TX_OUT <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      pre_q <= pre_d;
      TX_OUT <= tx_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  // The parity bit is resolved at pop time from the word and type being latched.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_en_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (FIFO_R_INC) begin
      par_en_q <= PAR_EN;
      par_bit_q <= ^FIFO_RD_DATA ^ PAR_TYP;
    end
  end
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FIFO_R_INC ? START : IDLE;
      START:  state_d = bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:   state_d = bit_end && last_bit ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY: state_d = bit_end ? STOP : PARITY;
`else
      DATA:   state_d = bit_end && last_bit ? STOP : DATA;
`endif
      STOP:   state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // TX_OUT is registered from the next state so the line changes on the same edge as the state.
  always_comb begin
    cnt_d = state_q == IDLE || bit_end ? '0 : cnt_q + CW'(1);
    bit_d = state_q != DATA || (bit_end && last_bit) ? '0 : bit_end ? bit_q + BW'(1) : bit_q;
    sh_d = FIFO_R_INC ? FIFO_RD_DATA : state_q == DATA && bit_end ? sh_q >> 1 : sh_q;
    pre_d = FIFO_R_INC ? (PRESCALE == '0 ? PRESCALE_WIDTH'(1) : PRESCALE) : pre_q;
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_bit_q : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
`endif
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: self-checking bench for uart_tx_fifo_drain against a bit-list frame model
module tb_uart_tx_fifo_drain;
  localparam int DW = 8;
  localparam int PW = 6;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic FIFO_EMPTY = 1'b1;
  logic [DW-1:0] FIFO_RD_DATA = '0;
  logic FIFO_R_INC;
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic [PW-1:0] PRESCALE = PW'(1);
  logic TX_OUT;
  logic BUSY;
  int tests = 0;
  int failed = 0;
  bit exp_q[$];

  uart_tx_fifo_drain #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_DATA(FIFO_RD_DATA),
    .FIFO_R_INC(FIFO_R_INC), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
    .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Expected line level per BUSY cycle: start, LSB-first data, optional parity, stop, each held P cycles.
  task automatic build_exp(input logic [DW-1:0] d, input bit pe, input bit pt, input int ps);
    int p;
    bit bits[$];
    p = ps == 0 ? 1 : ps;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    if (pe) bits.push_back(($countones(d) % 2 == 1) ^ pt);
`endif
    bits.push_back(1'b1);
    exp_q = {};
    foreach (bits[i]) repeat (p) exp_q.push_back(bits[i]);
  endtask

  // Presents one word in IDLE, samples the pop request, and releases the FIFO after the pop edge.
  task automatic pop_word(input logic [DW-1:0] d, input bit pe, input bit pt, input int ps, output bit popped);
    @(negedge CLK);
    FIFO_RD_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    PRESCALE = PW'(ps);
    FIFO_EMPTY = 1'b0;
    build_exp(d, pe, pt, ps);
    #1 popped = FIFO_R_INC;
    @(posedge CLK);
    #1 FIFO_EMPTY = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    FIFO_EMPTY = 1'b0;
    FIFO_RD_DATA = 8'h3C;
    repeat (3) begin
      @(negedge CLK);
      tests++;
      if (FIFO_R_INC !== 1'b0 || TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failed++;
        $display("FAIL reset_hold: inc=%b tx=%b busy=%b, want inc=0 tx=1 busy=0", FIFO_R_INC, TX_OUT, BUSY);
      end
    end
    RST = 1'b1;
    #1 tests++;
    if (FIFO_R_INC !== 1'b1) begin
      failed++;
      $display("FAIL reset_first_pop: inc=%b, want 1", FIFO_R_INC);
    end
    build_exp(8'h3C, 1'b0, 1'b0, 1);
    @(posedge CLK);
    #1 FIFO_EMPTY = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
        failed++;
        $display("FAIL reset_frame cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
      end
    end
  endtask

  task automatic test_single;
    bit popped;
    pop_word(8'hA5, 1'b0, 1'b0, 1, popped);
    tests++;
    if (popped !== 1'b1) begin
      failed++;
      $display("FAIL single_pop: inc=%b, want 1", popped);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
        failed++;
        $display("FAIL single_frame cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
      end
    end
    @(negedge CLK);
    tests++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_R_INC !== 1'b0) begin
      failed++;
      $display("FAIL single_idle: tx=%b busy=%b inc=%b, want tx=1 busy=0 inc=0", TX_OUT, BUSY, FIFO_R_INC);
    end
  endtask

  task automatic test_parity;
    bit popped;
    for (int t = 0; t < 2; t++) begin
      pop_word(8'hA5, 1'b1, t[0], 1, popped);
      tests++;
      if (popped !== 1'b1) begin
        failed++;
        $display("FAIL parity_pop typ=%0d: inc=%b, want 1", t, popped);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge CLK);
        tests++;
        if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
          failed++;
          $display("FAIL parity_frame typ=%0d cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", t, i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
        end
      end
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failed++;
        $display("FAIL parity_end typ=%0d: tx=%b busy=%b, want tx=1 busy=0", t, TX_OUT, BUSY);
      end
    end
  endtask

  // Cases: 0x01 at P=4, P=0 treated as 1, and PRESCALE/parity changed right after the pop.
  task automatic test_prescale;
    bit popped;
    logic [DW-1:0] d[3] = '{8'h01, 8'h5A, 8'hC3};
    int ps[3] = '{4, 0, 3};
    for (int c = 0; c < 3; c++) begin
      pop_word(d[c], 1'b0, 1'b0, ps[c], popped);
      if (c == 2) begin
        PRESCALE = PW'(2);
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
      end
      tests++;
      if (popped !== 1'b1) begin
        failed++;
        $display("FAIL prescale_pop case %0d: inc=%b, want 1", c, popped);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge CLK);
        tests++;
        if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
          failed++;
          $display("FAIL prescale_frame case %0d cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", c, i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
        end
      end
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failed++;
        $display("FAIL prescale_end case %0d: tx=%b busy=%b, want tx=1 busy=0", c, TX_OUT, BUSY);
      end
    end
  endtask

  task automatic test_random;
    bit popped;
    logic [DW-1:0] d;
    bit pe, pt;
    int ps;
    for (int n = 0; n < 10; n++) begin
      d = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = $urandom_range(0, 5);
      pop_word(d, pe, pt, ps, popped);
      if ($urandom_range(0, 1) == 1) begin
        PRESCALE = PW'($urandom_range(0, 7));
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
      tests++;
      if (popped !== 1'b1) begin
        failed++;
        $display("FAIL random_pop %0d: inc=%b, want 1", n, popped);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge CLK);
        tests++;
        if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
          failed++;
          $display("FAIL random_frame %0d d=%h pe=%b pt=%b p=%0d cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", n, d, pe, pt, ps, i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
        end
      end
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failed++;
        $display("FAIL random_end %0d: tx=%b busy=%b, want tx=1 busy=0", n, TX_OUT, BUSY);
      end
    end
  endtask

  // FIFO held non-empty across three words; each pop must land in the single idle cycle after a frame.
  task automatic test_back_to_back;
    logic [DW-1:0] w[3] = '{8'h11, 8'h22, 8'h33};
    @(negedge CLK);
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    PRESCALE = PW'(1);
    FIFO_RD_DATA = w[0];
    FIFO_EMPTY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge CLK);
      #1 tests++;
      if (FIFO_R_INC !== 1'b1 || TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failed++;
        $display("FAIL stream_gap %0d: inc=%b tx=%b busy=%b, want inc=1 tx=1 busy=0", k, FIFO_R_INC, TX_OUT, BUSY);
      end
      build_exp(w[k], 1'b0, 1'b0, 1);
      @(posedge CLK);
      #1;
      if (k < 2) FIFO_RD_DATA = w[k+1];
      else FIFO_EMPTY = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge CLK);
        tests++;
        if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
          failed++;
          $display("FAIL stream_frame %0d cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", k, i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_empty;
    repeat (12) begin
      @(negedge CLK);
      tests++;
      if (FIFO_R_INC !== 1'b0 || TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failed++;
        $display("FAIL empty_idle: inc=%b tx=%b busy=%b, want inc=0 tx=1 busy=0", FIFO_R_INC, TX_OUT, BUSY);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit popped;
    logic [DW-1:0] nw;
    int ps;
    pop_word(8'hFF, 1'b0, 1'b0, 1, popped);
    tests++;
    if (popped !== 1'b1) begin
      failed++;
      $display("FAIL midrst_pop: inc=%b, want 1", popped);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_q[i] || BUSY !== 1'b1) begin
        failed++;
        $display("FAIL midrst_pre cyc %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, BUSY, exp_q[i]);
      end
    end
    nw = DW'($urandom_range(0, 127) * 2);
    ps = $urandom_range(1, 3);
    RST = 1'b0;
    FIFO_EMPTY = 1'b0;
    FIFO_RD_DATA = nw;
    PRESCALE = PW'(ps);
    @(negedge CLK);
    tests++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_R_INC !== 1'b0) begin
      failed++;
      $display("FAIL midrst_abort: tx=%b busy=%b inc=%b, want tx=1 busy=0 inc=0", TX_OUT, BUSY, FIFO_R_INC);
    end
    RST = 1'b1;
    #1 tests++;
    if (FIFO_R_INC !== 1'b1) begin
      failed++;
      $display("FAIL midrst_repop: inc=%b, want 1", FIFO_R_INC);
    end
    build_exp(nw, 1'b0, 1'b0, ps);
    @(posedge CLK);
    #1 FIFO_EMPTY = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_q[i] || BUSY !== 1'b1 || FIFO_R_INC !== 1'b0) begin
        failed++;
        $display("FAIL midrst_frame cyc %0d: tx=%b busy=%b inc=%b, want tx=%b busy=1 inc=0", i, TX_OUT, BUSY, FIFO_R_INC, exp_q[i]);
      end
    end
    @(negedge CLK);
    tests++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      failed++;
      $display("FAIL midrst_end: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, BUSY);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_parity;
    test_prescale;
    test_random;
    test_back_to_back;
    test_empty;
    test_reset_mid;
    test_empty;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
